// File: rtl/uart_pkg.sv
// Shared types and constants for the UART echo responder.
package uart_pkg;

    localparam int ECHO_CNT_W = 16;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        DONE
    } echo_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Single-clock byte FIFO with a registered head so consumers see no
// combinational path from push/pop to the offered byte.
module uart_fifo #(
    parameter int depth = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [7:0]             data_in,
    output logic [7:0]             head,
    output logic [$clog2(depth):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PW = $clog2(depth);
    localparam int CW = PW + 1;

    logic [7:0]    ram [depth];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_next;

    assign rd_next = rd_ptr + 1'b1;
    assign full    = (count == CW'(depth));
    assign empty   = (count == '0);

    always_ff @(posedge clock) begin
        if (push) begin
            ram[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_next;
            end
            if (push && !pop && !full) begin
                count <= count + 1'b1;
            end else if (pop && !push && !empty) begin
                count <= count - 1'b1;
            end
            // Head bypasses the RAM whenever the incoming byte becomes the new head.
            if (pop) begin
                if (count == CW'(1)) begin
                    if (push) begin
                        head <= data_in;
                    end
                end else begin
                    head <= ram[rd_next];
                end
            end else if (empty && push) begin
                head <= data_in;
            end
        end
    end

endmodule

// File: rtl/uart_echo.sv
// Receive-side echo client: buffers received bytes, re-offers them to the
// transmitter, accumulates a checksum and flags completion of one message.
module uart_echo
    import uart_pkg::*;
#(
    parameter int depth       = 16,
    parameter int message_len = 16
) (
    input  logic                   clock,
    input  logic                   tick_reset,
    input  logic                   tick_valid,
    input  logic [7:0]             tick_data_in,
    input  logic                   tick_clear_to_send,
    input  logic                   tick_idle,
    output logic [7:0]             get_data_ret,
    output logic                   get_request_ret,
    output logic [$clog2(depth):0] get_count_ret,
    output logic                   get_overflow_ret,
    output logic [31:0]            get_checksum_ret,
    output logic                   get_done_ret
);

    localparam logic [ECHO_CNT_W-1:0] LAST = ECHO_CNT_W'(message_len - 1);

    echo_state_t           state;
    logic [ECHO_CNT_W-1:0] rx_cnt;
    logic                  full;
    logic                  empty;
    logic                  rx_active;
    logic                  push;
    logic                  pop;
    logic                  drop;

    assign get_request_ret = !empty && (state != DONE);
    assign get_done_ret    = (state == DONE);

    always_comb begin
        rx_active = tick_valid && (state == RUN);
        pop       = get_request_ret && tick_clear_to_send;
        push      = rx_active && (!full || pop);
        drop      = rx_active && full && !pop;
    end

    uart_fifo #(
        .depth(depth)
    ) u_fifo (
        .clock  (clock),
        .reset  (tick_reset),
        .push   (push),
        .pop    (pop),
        .data_in(tick_data_in),
        .head   (get_data_ret),
        .count  (get_count_ret),
        .full   (full),
        .empty  (empty)
    );

    always_ff @(posedge clock) begin
        if (tick_reset) begin
            state            <= RUN;
            rx_cnt           <= '0;
            get_overflow_ret <= 1'b0;
            get_checksum_ret <= '0;
        end else begin
            if (pop) begin
                get_checksum_ret <= get_checksum_ret + {24'd0, get_data_ret};
            end
            if (drop) begin
                get_overflow_ret <= 1'b1;
            end
            case (state)
                RUN: begin
                    if (rx_active) begin
                        rx_cnt <= rx_cnt + 1'b1;
                        if (rx_cnt == LAST) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (empty && tick_idle) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_echo.sv
// Directed bench for uart_echo: three instances cover basic echo, FIFO
// backpressure/overflow/reset at depth 4, and drain gating.
module tb_uart_echo;
    import uart_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Instance A: depth 16, message_len 4
    logic       reset_a, valid_a, cts_a, idle_a;
    logic [7:0] din_a, data_a;
    logic       req_a, ovf_a, done_a;
    logic [4:0] count_a;
    logic [31:0] sum_a;

    // Instance B: depth 4, message_len 16
    logic       reset_b, valid_b, cts_b, idle_b;
    logic [7:0] din_b, data_b;
    logic       req_b, ovf_b, done_b;
    logic [2:0] count_b;
    logic [31:0] sum_b;

    // Instance C: depth 4, message_len 2
    logic       reset_c, valid_c, cts_c, idle_c;
    logic [7:0] din_c, data_c;
    logic       req_c, ovf_c, done_c;
    logic [2:0] count_c;
    logic [31:0] sum_c;

    uart_echo #(.depth(16), .message_len(4)) dut_a (
        .clock(clock), .tick_reset(reset_a), .tick_valid(valid_a), .tick_data_in(din_a),
        .tick_clear_to_send(cts_a), .tick_idle(idle_a), .get_data_ret(data_a),
        .get_request_ret(req_a), .get_count_ret(count_a), .get_overflow_ret(ovf_a),
        .get_checksum_ret(sum_a), .get_done_ret(done_a)
    );

    uart_echo #(.depth(4), .message_len(16)) dut_b (
        .clock(clock), .tick_reset(reset_b), .tick_valid(valid_b), .tick_data_in(din_b),
        .tick_clear_to_send(cts_b), .tick_idle(idle_b), .get_data_ret(data_b),
        .get_request_ret(req_b), .get_count_ret(count_b), .get_overflow_ret(ovf_b),
        .get_checksum_ret(sum_b), .get_done_ret(done_b)
    );

    uart_echo #(.depth(4), .message_len(2)) dut_c (
        .clock(clock), .tick_reset(reset_c), .tick_valid(valid_c), .tick_data_in(din_c),
        .tick_clear_to_send(cts_c), .tick_idle(idle_c), .get_data_ret(data_c),
        .get_request_ret(req_c), .get_count_ret(count_c), .get_overflow_ret(ovf_c),
        .get_checksum_ret(sum_c), .get_done_ret(done_c)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic push_b(input logic [7:0] v);
        valid_b = 1'b1;
        din_b   = v;
        step();
        valid_b = 1'b0;
    endtask

    task automatic push_c(input logic [7:0] v);
        valid_c = 1'b1;
        din_c   = v;
        step();
        valid_c = 1'b0;
    endtask

    logic [7:0]  msg [4];
    logic [31:0] sum_exp;

    initial begin
        msg = '{8'h48, 8'h65, 8'h6C, 8'h6C};
        {valid_a, cts_a, idle_a, din_a} = '0;
        {valid_b, cts_b, idle_b, din_b} = '0;
        {valid_c, cts_c, idle_c, din_c} = '0;
        reset_a = 1'b1;
        reset_b = 1'b1;
        reset_c = 1'b1;
        step();
        step();

        // Reset values
        chk("rst_data_b", data_b, 0);
        chk("rst_req_b", req_b, 0);
        chk("rst_count_b", count_b, 0);
        chk("rst_ovf_b", ovf_b, 0);
        chk("rst_sum_b", sum_b, 0);
        chk("rst_done_b", done_b, 0);
        chk("rst_state_b", 32'(dut_b.state), 32'(RUN));
        chk("rst_count_a", count_a, 0);
        reset_a = 1'b0;
        reset_b = 1'b0;
        reset_c = 1'b0;

        // Basic echo on A: each byte popped the cycle after its push
        cts_a   = 1'b1;
        idle_a  = 1'b1;
        sum_exp = 32'h0;
        for (int i = 0; i < 4; i++) begin
            valid_a = 1'b1;
            din_a   = msg[i];
            step();
            valid_a = 1'b0;
            chk("echo_req_up", req_a, 1);
            chk("echo_head", data_a, msg[i]);
            step();
            sum_exp = sum_exp + 32'(msg[i]);
            chk("echo_req_down", req_a, 0);
            chk("echo_sum", sum_a, sum_exp);
            if (i < 3) begin
                repeat (8) step();
            end
        end
        chk("echo_done_early", done_a, 0);
        chk("echo_sum_total", sum_a, 32'h0000_0185);
        step();
        chk("echo_done", done_a, 1);

        // Backpressure and order on B
        idle_b = 1'b1;
        for (int v = 1; v <= 4; v++) push_b(8'(v));
        chk("bp_count_full", count_b, 4);
        chk("bp_req", req_b, 1);
        chk("bp_rx_cnt", dut_b.rx_cnt, 4);
        cts_b = 1'b1;
        for (int v = 1; v <= 4; v++) begin
            chk("bp_order", data_b, v);
            step();
        end
        cts_b = 1'b0;
        chk("bp_count_empty", count_b, 0);
        chk("bp_req_empty", req_b, 0);
        chk("bp_sum", sum_b, 32'h0A);

        // Simultaneous push and pop at full
        for (int v = 5; v <= 8; v++) push_b(8'(v));
        chk("sim_full", count_b, 4);
        valid_b = 1'b1;
        din_b   = 8'h09;
        cts_b   = 1'b1;
        step();
        valid_b = 1'b0;
        cts_b   = 1'b0;
        chk("sim_count", count_b, 4);
        chk("sim_no_ovf", ovf_b, 0);
        chk("sim_head", data_b, 6);
        cts_b = 1'b1;
        for (int v = 6; v <= 9; v++) begin
            chk("sim_order", data_b, v);
            step();
        end
        cts_b = 1'b0;
        chk("sim_count_empty", count_b, 0);
        chk("sim_sum", sum_b, 32'h2D);

        // Overflow at full, from a fresh reset
        reset_b = 1'b1;
        step();
        reset_b = 1'b0;
        chk("ovf_rst_sum", sum_b, 0);
        for (int v = 16; v <= 20; v++) push_b(8'(v));
        chk("ovf_count", count_b, 4);
        chk("ovf_flag", ovf_b, 1);
        chk("ovf_rx_cnt", dut_b.rx_cnt, 5);
        cts_b = 1'b1;
        for (int v = 16; v <= 19; v++) begin
            chk("ovf_order", data_b, v);
            step();
        end
        cts_b = 1'b0;
        chk("ovf_count_empty", count_b, 0);
        chk("ovf_sum", sum_b, 32'h46);
        chk("ovf_sticky", ovf_b, 1);

        // Reset mid-message with concurrent valid and pop
        reset_b = 1'b1;
        step();
        reset_b = 1'b0;
        for (int v = 33; v <= 36; v++) push_b(8'(v));
        cts_b = 1'b1;
        step();
        cts_b = 1'b0;
        chk("mid_count", count_b, 3);
        chk("mid_sum", sum_b, 32'h21);
        reset_b = 1'b1;
        valid_b = 1'b1;
        din_b   = 8'h55;
        cts_b   = 1'b1;
        step();
        reset_b = 1'b0;
        valid_b = 1'b0;
        cts_b   = 1'b0;
        chk("mid_data", data_b, 0);
        chk("mid_req", req_b, 0);
        chk("mid_count_rst", count_b, 0);
        chk("mid_ovf", ovf_b, 0);
        chk("mid_sum_rst", sum_b, 0);
        chk("mid_done", done_b, 0);
        chk("mid_state", 32'(dut_b.state), 32'(RUN));
        chk("mid_rx_cnt", dut_b.rx_cnt, 0);

        // Drain gating on C
        push_c(8'hA1);
        push_c(8'hA2);
        chk("gate_count2", count_c, 2);
        chk("gate_drain", 32'(dut_c.state), 32'(DRAIN));
        push_c(8'hA3);
        chk("gate_ignored", count_c, 2);
        chk("gate_rx_cnt", dut_c.rx_cnt, 2);
        chk("gate_no_ovf", ovf_c, 0);
        cts_c = 1'b1;
        step();
        step();
        cts_c = 1'b0;
        chk("gate_empty", count_c, 0);
        chk("gate_sum", sum_c, 32'h143);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("gate_hold", done_c, 0);
        end
        idle_c = 1'b1;
        chk("gate_pre_idle", done_c, 0);
        step();
        chk("gate_done", done_c, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
